// File: rtl/vmicro16_periph_arbiter_pkg.sv
// Shared constants and types for the peripheral-bus arbiter and its
// round-robin picker.
package vmicro16_periph_arbiter_pkg;

  localparam int unsigned PERI_ARB_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_t;

  // Index width for a counter/selector covering n values; never below 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vmicro16_rr_arbiter.sv
// Combinational rotate-priority picker: first set request at or after ptr,
// wrapping modulo MASTERS. Shared by the bus arbiters.
module vmicro16_rr_arbiter
  import vmicro16_periph_arbiter_pkg::*;
#(
  parameter int unsigned MASTERS = 4,
  parameter int unsigned IDX_W   = idx_width(MASTERS)
) (
  input  logic [MASTERS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  int unsigned cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < MASTERS; k++) begin
      cand     = (32'(ptr) + (MASTERS - 1 - k)) % MASTERS;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        gnt           = '0;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/vmicro16_periph_arbiter.sv
// Round-robin APB arbiter sharing the peripheral section's single master port
// between MASTERS cores, one transfer in flight, with a PREADY watchdog.
module vmicro16_periph_arbiter
  import vmicro16_periph_arbiter_pkg::*;
#(
  parameter int unsigned MASTERS    = 4,
  parameter int unsigned BUS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT    = PERI_ARB_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [MASTERS*BUS_WIDTH-1:0]    S_PADDR,
  input  logic [MASTERS-1:0]              S_PWRITE,
  input  logic [MASTERS-1:0]              S_PSELx,
  input  logic [MASTERS-1:0]              S_PENABLE,
  input  logic [MASTERS*DATA_WIDTH-1:0]   S_PWDATA,
  output logic [MASTERS*DATA_WIDTH-1:0]   S_PRDATA,
  output logic [MASTERS-1:0]              S_PREADY,
  output logic [BUS_WIDTH-1:0]            M_PADDR,
  output logic                            M_PWRITE,
  output logic                            M_PSELx,
  output logic                            M_PENABLE,
  output logic [DATA_WIDTH-1:0]           M_PWDATA,
  input  logic [DATA_WIDTH-1:0]           M_PRDATA,
  input  logic                            M_PREADY,
  output logic [MASTERS-1:0]              grant_o,
  output logic                            timeout_o
);

  localparam int unsigned IDX_W   = idx_width(MASTERS);
  localparam int unsigned WD_W    = idx_width(TIMEOUT + 1);
  localparam int unsigned WD_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  arb_state_t state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] g_idx;
  logic [WD_W-1:0]  wdog;

  logic [MASTERS-1:0]            pick_gnt;
  logic [IDX_W-1:0]              pick_idx;
  logic [BUS_WIDTH-1:0]          sel_addr;
  logic [DATA_WIDTH-1:0]         sel_wdata;
  logic                          sel_write;
  logic [DATA_WIDTH-1:0]         done_data;
  logic [MASTERS*DATA_WIDTH-1:0] done_vec;
  logic                          wdog_expired;
  logic                          unused_penable;

  assign unused_penable = ^S_PENABLE;

  vmicro16_rr_arbiter #(
    .MASTERS (MASTERS),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req (S_PSELx),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // One-hot muxes keep all slice indices constant after unrolling.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      if (pick_gnt[i]) begin
        sel_addr  = S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
        sel_wdata = S_PWDATA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_write = S_PWRITE[i];
      end
    end
  end

  assign wdog_expired = (TIMEOUT != 0) && (wdog == WD_W'(WD_LAST));
  assign done_data    = M_PREADY ? M_PRDATA : '1;

  always_comb begin
    done_vec = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      if (grant_o[i]) done_vec[i*DATA_WIDTH +: DATA_WIDTH] = done_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      g_idx     <= '0;
      wdog      <= '0;
      grant_o   <= '0;
      M_PADDR   <= '0;
      M_PWRITE  <= 1'b0;
      M_PWDATA  <= '0;
      M_PSELx   <= 1'b0;
      M_PENABLE <= 1'b0;
      S_PREADY  <= '0;
      S_PRDATA  <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (|S_PSELx) begin
            M_PADDR   <= sel_addr;
            M_PWRITE  <= sel_write;
            M_PWDATA  <= sel_wdata;
            grant_o   <= pick_gnt;
            g_idx     <= pick_idx;
            M_PSELx   <= 1'b1;
            M_PENABLE <= 1'b0;
            state     <= ARB_SETUP;
          end
        end
        ARB_SETUP: begin
          M_PENABLE <= 1'b1;
          wdog      <= '0;
          state     <= ARB_ACCESS;
        end
        ARB_ACCESS: begin
          if (M_PREADY || wdog_expired) begin
            M_PSELx   <= 1'b0;
            M_PENABLE <= 1'b0;
            S_PREADY  <= grant_o;
            S_PRDATA  <= done_vec;
            timeout_o <= !M_PREADY;
            state     <= ARB_DONE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ARB_DONE: begin
          S_PREADY <= '0;
          S_PRDATA <= '0;
          grant_o  <= '0;
          ptr      <= (g_idx == IDX_W'(MASTERS - 1)) ? '0 : g_idx + 1'b1;
          state    <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmicro16_periph_arbiter.sv
// Scoreboard bench for the peripheral arbiter: directed transfers push
// expected completions, a negedge monitor pops and checks them.
module tb_vmicro16_periph_arbiter;

  localparam int M  = 4;
  localparam int BW = 16;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [M*BW-1:0]   S_PADDR;
  logic [M-1:0]      S_PWRITE;
  logic [M-1:0]      S_PSELx;
  logic [M-1:0]      S_PENABLE;
  logic [M*DW-1:0]   S_PWDATA;
  logic [M*DW-1:0]   S_PRDATA;
  logic [M-1:0]      S_PREADY;
  logic [BW-1:0]     M_PADDR;
  logic              M_PWRITE;
  logic              M_PSELx;
  logic              M_PENABLE;
  logic [DW-1:0]     M_PWDATA;
  logic [DW-1:0]     M_PRDATA;
  logic              M_PREADY;
  logic [M-1:0]      grant_o;
  logic              timeout_o;

  vmicro16_periph_arbiter #(
    .MASTERS    (M),
    .BUS_WIDTH  (BW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .S_PADDR   (S_PADDR),
    .S_PWRITE  (S_PWRITE),
    .S_PSELx   (S_PSELx),
    .S_PENABLE (S_PENABLE),
    .S_PWDATA  (S_PWDATA),
    .S_PRDATA  (S_PRDATA),
    .S_PREADY  (S_PREADY),
    .M_PADDR   (M_PADDR),
    .M_PWRITE  (M_PWRITE),
    .M_PSELx   (M_PSELx),
    .M_PENABLE (M_PENABLE),
    .M_PWDATA  (M_PWDATA),
    .M_PRDATA  (M_PRDATA),
    .M_PREADY  (M_PREADY),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  typedef struct {
    int        core;
    logic [15:0] data;
    logic      to;
    int        at;
  } exp_t;
  exp_t sb[$];

  // Slave model: PREADY after slave_waits ACCESS cycles.
  int          slave_waits = 0;
  int          wcnt = 0;
  logic [15:0] slave_rdata = 16'h0F0F;
  always @(negedge clk) begin
    M_PRDATA = slave_rdata;
    if (!reset && M_PSELx && M_PENABLE) begin
      M_PREADY = (wcnt == slave_waits);
      wcnt++;
    end else begin
      M_PREADY = 1'b0;
      wcnt = 0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset && S_PREADY != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_pready", {60'd0, S_PREADY}, 64'd0);
      end else begin
        exp_t e;
        logic [M*DW-1:0] ev;
        logic [M-1:0]    eh;
        e  = sb.pop_front();
        ev = '0;
        ev[e.core*DW +: DW] = e.data;
        eh = '0;
        eh[e.core] = 1'b1;
        chk("pready_core", {60'd0, S_PREADY}, {60'd0, eh});
        chk("prdata",      S_PRDATA, ev);
        chk("grant_done",  {60'd0, grant_o}, {60'd0, eh});
        chk("timeout",     {63'd0, timeout_o}, {63'd0, e.to});
        chk("latency",     64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic set_core(input int c, input logic [15:0] addr,
                          input logic [15:0] wd, input logic wr);
    S_PADDR[c*BW +: BW]  = addr;
    S_PWDATA[c*DW +: DW] = wd;
    S_PWRITE[c]          = wr;
  endtask

  task automatic req(input logic [M-1:0] r);
    S_PSELx   = r;
    S_PENABLE = r;
  endtask

  task automatic push(input int core, input logic [15:0] d, input logic to, input int at);
    exp_t e;
    e.core = core; e.data = d; e.to = to; e.at = at;
    sb.push_back(e);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mpsel"},  {63'd0, M_PSELx},   64'd0);
    chk({tag, "_mpen"},   {63'd0, M_PENABLE}, 64'd0);
    chk({tag, "_spready"},{60'd0, S_PREADY},  64'd0);
    chk({tag, "_sprdata"},S_PRDATA,           64'd0);
    chk({tag, "_grant"},  {60'd0, grant_o},   64'd0);
    chk({tag, "_tmo"},    {63'd0, timeout_o}, 64'd0);
    chk({tag, "_maddr"},  {48'd0, M_PADDR},   64'd0);
  endtask

  int c;

  initial begin
    reset = 1'b1;
    S_PADDR = '0; S_PWDATA = '0; S_PWRITE = '0; S_PSELx = '0; S_PENABLE = '0;
    M_PRDATA = '0; M_PREADY = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // 1: single write from core 0, zero-wait slave
    slave_waits = 0; slave_rdata = 16'h0F0F;
    c = cyc;
    push(0, 16'h0F0F, 1'b0, c + 3);
    set_core(0, 16'h0010, 16'h00A5, 1'b1);
    req(4'b0001);
    @(posedge clk); #1 req(4'b0000);
    @(negedge clk);
    chk("t1_setup_psel", {63'd0, M_PSELx},   64'd1);
    chk("t1_setup_pen",  {63'd0, M_PENABLE}, 64'd0);
    chk("t1_grant",      {60'd0, grant_o},   64'd1);
    chk("t1_paddr",      {48'd0, M_PADDR},   64'h0010);
    chk("t1_pwdata",     {48'd0, M_PWDATA},  64'h00A5);
    chk("t1_pwrite",     {63'd0, M_PWRITE},  64'd1);
    @(negedge clk);
    chk("t1_access_pen", {63'd0, M_PENABLE}, 64'd1);
    repeat (4) @(posedge clk);

    // 2: all four cores held -> 0,1,2,3,0 every 4 cycles
    reset_dut();
    c = cyc;
    for (int i = 0; i < 5; i++) push(i % M, 16'h0F0F, 1'b0, c + 3 + 4 * i);
    for (int i = 0; i < M; i++) set_core(i, 16'h0100 + 16'(i), 16'h1000 + 16'(i), 1'b1);
    req(4'b1111);
    repeat (18) @(posedge clk);
    #1 req(4'b0000);
    repeat (6) @(posedge clk);

    // 3: core 1 read, 5-wait slave
    reset_dut();
    slave_waits = 5; slave_rdata = 16'h1234;
    c = cyc;
    push(1, 16'h1234, 1'b0, c + 8);
    set_core(1, 16'h0030, 16'h0000, 1'b0);
    req(4'b0010);
    @(posedge clk); #1 req(4'b0000);
    repeat (10) @(posedge clk);

    // 4: slave never ready, watchdog after 8 ACCESS cycles
    slave_waits = 1000;
    #1 c = cyc;
    push(3, 16'hFFFF, 1'b1, c + 10);
    set_core(3, 16'h0040, 16'h0000, 1'b0);
    req(4'b1000);
    @(posedge clk); #1 req(4'b0000);
    repeat (12) @(posedge clk);

    // 5: reset during ACCESS clears everything and the pointer
    reset_dut();
    slave_waits = 0; slave_rdata = 16'h0F0F;
    c = cyc;
    push(2, 16'h0F0F, 1'b0, c + 3);
    set_core(2, 16'h0050, 16'h0055, 1'b1);
    req(4'b0100);
    @(posedge clk); #1 req(4'b0000);
    repeat (5) @(posedge clk);
    #1 slave_waits = 1000;
    set_core(1, 16'h0060, 16'h0066, 1'b1);
    req(4'b0010);
    @(posedge clk); #1 req(4'b0000);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("t5_in_access", {63'd0, M_PENABLE}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    check_all_zero("t5_reset");
    @(posedge clk); #1 reset = 1'b0;
    slave_waits = 0;
    c = cyc;
    push(1, 16'h0F0F, 1'b0, c + 3);
    set_core(3, 16'h0070, 16'h0077, 1'b1);
    req(4'b1010);
    @(posedge clk); #1 req(4'b0000);
    repeat (6) @(posedge clk);

    // 6: core 2 changes PADDR/PWDATA after grant
    reset_dut();
    slave_waits = 3;
    c = cyc;
    push(2, 16'h0F0F, 1'b0, c + 6);
    set_core(2, 16'h0222, 16'h2222, 1'b1);
    req(4'b0100);
    @(posedge clk); #1 req(4'b0000);
    set_core(2, 16'hBEEF, 16'hDEAD, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t6_paddr",  {48'd0, M_PADDR},  64'h0222);
    chk("t6_pwdata", {48'd0, M_PWDATA}, 64'h2222);
    chk("t6_pwrite", {63'd0, M_PWRITE}, 64'd1);
    repeat (6) @(posedge clk);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d required < 20000", cyc);
    $fatal(1);
  end

endmodule
